bcd_cascade_counter: RTL and testbench

Parametrised synchronous multi-digit modulo counter. It is the next generation of the decade counter in the 74LSXX library.
- DIGITS cascaded digit stages, each counting modulo MOD, all clocked from a single edge (no ripple clocking).
- Adds what the single decade counter lacks: up/down direction, synchronous parallel load, count enable, and a terminal-count carry for chaining instances.
- Keeps the library's reset-to-0 (R0) and set-to-9 (R9) controls, generalised so R9 sets every digit to MOD-1.

---
 rtl/bcd_cascade_counter_if.sv | 16 +
 rtl/bcd_cascade_counter.sv | 47 ++++
 tb/tb_bcd_cascade_counter.sv | 100 ++++++++++
 3 files changed

// File: rtl/bcd_cascade_counter_if.sv
// bcd_cascade_counter_if: control, data and status bundle of the cascade counter
// master drives R0, R9, LD_n, D, EN, UP and observes Q, CO; slave is the counter side
interface bcd_cascade_counter_if #(
    parameter int DIGITS = 4
);
    logic                r0;
    logic                r9;
    logic                ld_n;
    logic                en;
    logic                up;
    logic [4*DIGITS-1:0] d;
    logic [4*DIGITS-1:0] q;
    logic                co;
    modport master (output r0, r9, ld_n, en, up, d, input q, co);
    modport slave (input r0, r9, ld_n, en, up, d, output q, co);
endinterface

// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter: DIGITS-stage synchronous modulo-MOD up/down counter with load, R0/R9 and cascade carry
// CP rising-edge clock, CR_n async active-low clear; bus carries r0, r9, ld_n, d, en, up in and q, co out
module bcd_cascade_counter #(
    parameter int DIGITS = 4,
    parameter int MOD    = 10
) (
    input logic                  CP,
    input logic                  CR_n,
    bcd_cascade_counter_if.slave bus
);
    localparam logic [3:0] MAX = 4'(MOD - 1);
    logic [4*DIGITS-1:0] q_q, q_d;
    logic [3:0]          dig, ld;
    logic                up_c, dn_c;
    // up_c/dn_c accumulate "all lower digits at MAX / at 0", which is each digit's step enable
    always_comb begin
        q_d  = q_q;
        up_c = 1'b1;
        dn_c = 1'b1;
        dig  = '0;
        ld   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = q_q[4*k +: 4];
            ld  = bus.d[4*k +: 4];
            if (bus.r9)
                q_d[4*k +: 4] = MAX;
            else if (bus.r0)
                q_d[4*k +: 4] = '0;
            else if (!bus.ld_n)
                q_d[4*k +: 4] = ld > MAX ? MAX : ld;
            else if (bus.en && bus.up && up_c)
                q_d[4*k +: 4] = dig == MAX ? 4'd0 : dig + 4'd1;
            else if (bus.en && !bus.up && dn_c)
                q_d[4*k +: 4] = dig == 4'd0 ? MAX : dig - 4'd1;
            up_c = up_c & (dig == MAX);
            dn_c = dn_c & (dig == 4'd0);
        end
    end
    always_ff @(posedge CP or negedge CR_n) begin
        if (!CR_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end
    assign bus.q  = q_q;
    assign bus.co = bus.en & (bus.up ? up_c : dn_c);
endmodule

// File: tb/tb_bcd_cascade_counter.sv
// tb_bcd_cascade_counter: table-driven and sequence checks of bcd_cascade_counter, plus a two-instance cascade
module tb_bcd_cascade_counter;
    logic clk = 1'b0;
    logic cr_n = 1'b1;
    logic crc_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    bcd_cascade_counter_if #(.DIGITS(4)) b ();
    bcd_cascade_counter_if #(.DIGITS(2)) bl ();
    bcd_cascade_counter_if #(.DIGITS(2)) bh ();
    bcd_cascade_counter #(.DIGITS(4), .MOD(10)) u_dut (.CP(clk), .CR_n(cr_n), .bus(b.slave));
    bcd_cascade_counter #(.DIGITS(2), .MOD(6)) u_lo (.CP(clk), .CR_n(crc_n), .bus(bl.slave));
    bcd_cascade_counter #(.DIGITS(2), .MOD(6)) u_hi (.CP(clk), .CR_n(crc_n), .bus(bh.slave));
    assign bh.en = bl.co;
    typedef struct {
        logic        r9, r0, ld_n, en, up;
        logic [15:0] d, q;
        logic        co;
    } vec_t;
    vec_t tv [16];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [7:0] enc6(input int n);
        return 8'(((n / 6) << 4) | (n % 6));
    endfunction
    initial begin
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9998, 16'h9998, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h9998, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h9999, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFA3C, 16'h9939, 1'b0};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h9939, 1'b0};
        tv[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b1};
        tv[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        tv[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0};
        tv[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1};
        b.r9 = 1'b0; b.r0 = 1'b0; b.ld_n = 1'b1; b.en = 1'b0; b.up = 1'b1; b.d = '0;
        bl.r9 = 1'b0; bl.r0 = 1'b0; bl.ld_n = 1'b1; bl.en = 1'b1; bl.up = 1'b1; bl.d = '0;
        bh.r9 = 1'b0; bh.r0 = 1'b0; bh.ld_n = 1'b1; bh.up = 1'b1; bh.d = '0;
        #12;
        cr_n = 1'b0;
        #2;
        chk("async_clear", 32'(b.q), 32'h0000);
        step();
        cr_n = 1'b1;
        b.en = 1'b1;
        b.up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("count12_co", 32'(b.co), 32'h0);
        end
        chk("count12_q", 32'(b.q), 32'h0012);
        for (int i = 0; i < 16; i++) begin
            b.r9 = tv[i].r9; b.r0 = tv[i].r0; b.ld_n = tv[i].ld_n;
            b.en = tv[i].en; b.up = tv[i].up; b.d = tv[i].d;
            step();
            chk($sformatf("vec%0d_q", i), 32'(b.q), 32'(tv[i].q));
            chk($sformatf("vec%0d_co", i), 32'(b.co), 32'(tv[i].co));
        end
        b.r9 = 1'b0; b.r0 = 1'b0; b.ld_n = 1'b1; b.en = 1'b1; b.up = 1'b1;
        repeat (3) step();
        chk("pre_clear_q", 32'(b.q), 32'h0003);
        cr_n = 1'b0;
        #1;
        chk("mid_clear_q", 32'(b.q), 32'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_clear_q", 32'(b.q), 32'h0000);
        end
        cr_n = 1'b1;
        step();
        chk("post_clear_q", 32'(b.q), 32'h0001);
        crc_n = 1'b1;
        chk("cascade_reset", {16'h0, bh.q, bl.q}, 32'h0000);
        for (int n = 1; n <= 1300; n++) begin
            step();
            chk($sformatf("cascade_q%0d", n), {16'h0, bh.q, bl.q},
                {16'h0, enc6((n / 36) % 36), enc6(n % 36)});
            chk($sformatf("cascade_co%0d", n), 32'(bh.co), 32'(n % 1296 == 1295));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
